// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter owning the select of a shared 16:1 mux.
// Grant, select and valid are registered. The owner keeps the mux until it
// releases or drops its request. There is one dead cycle between owners, so the
// mux select never changes while valid_out is high.
// Optional build macro ARB_TIMEOUT_EN: bounds ownership to HOLD_MAX cycles and
// pulses timeout_out on a forced release. Without it, timeout_out is tied low.
module mux16_rr_arbiter #(
    parameter int HOLD_MAX = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] req_in,
    input  logic        release_in,
    output logic [15:0] grant_out,
    output logic [3:0]  sel_out,
    output logic        valid_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    state_t      state_reg;
    logic [3:0]  ptr_reg;      // index of the most recently released owner
    logic [15:0] rot_req;      // requests rotated so bit 0 is the index just above ptr_reg
    logic [3:0]  off_next;     // offset of the winner inside rot_req
    logic [3:0]  win_next;     // absolute index of the winner
    logic        any_req;
    logic        owner_done;

    // Reject hold limits that do not fit the 8-bit counter.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be in 1..255");
    end

    // Rotate the request vector so the search always starts just above the last owner.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
        assign rot_req[gi] = req_in[ptr_reg + 4'(gi + 1)];
    end

    // Find the lowest set bit of the rotated vector.
    always_comb begin
        off_next = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (rot_req[k]) begin
                off_next = 4'(k);
            end
        end
    end

    assign any_req    = |req_in;
    assign win_next   = ptr_reg + off_next + 4'd1;
    assign owner_done = release_in | ~req_in[sel_out];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_reg;
    logic       timeout_reg;
    logic       hold_hit;

    assign hold_hit    = (hold_cnt_reg == 8'(HOLD_MAX - 1));
    assign timeout_out = timeout_reg;
`else
    assign timeout_out = 1'b0;
`endif

    // Arbitration state machine with registered grant, select and valid.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= IDLE;
            grant_out    <= 16'd0;
            sel_out      <= 4'd0;
            valid_out    <= 1'b0;
            ptr_reg      <= 4'd15;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_out    <= 16'd1 << win_next;
                        sel_out      <= win_next;
                        valid_out    <= 1'b1;
                        state_reg    <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_reg <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    // A voluntary release or a dropped request wins over the timeout.
                    if (owner_done) begin
                        grant_out <= 16'd0;
                        valid_out <= 1'b0;
                        ptr_reg   <= sel_out;
                        state_reg <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_hit) begin
                        grant_out   <= 16'd0;
                        valid_out   <= 1'b0;
                        ptr_reg     <= sel_out;
                        state_reg   <= IDLE;
                        timeout_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_out <= 16'd0;
                    sel_out   <= 4'd0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_mux16_rr_arbiter;

    localparam int HOLD = 4;

    logic        clk_in;
    logic        rst_n_in;
    logic [15:0] req_in;
    logic        release_in;
    logic [15:0] grant_out;
    logic [3:0]  sel_out;
    logic        valid_out;
    logic        timeout_out;

    int n_vec;
    int n_err;

    // Behavioural model state: owner index or -1 when nobody holds the mux.
    int m_owner;
    int m_last;
    int m_sel;
    int m_held;
    bit m_to;

    typedef struct packed {
        logic [15:0] req;
        logic        rel;
        logic [15:0] g;
        logic [3:0]  s;
        logic        v;
    } vec_t;

    vec_t tbl [0:16];

    mux16_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .req_in      (req_in),
        .release_in  (release_in),
        .grant_out   (grant_out),
        .sel_out     (sel_out),
        .valid_out   (valid_out),
        .timeout_out (timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 15;
        m_sel   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // One clock edge of the arbitration rules, using the inputs seen at that edge.
    task automatic model_step(input logic [15:0] req, input logic rel);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 16; k++) begin
                if (m_owner < 0 && req[(m_last + k) % 16]) begin
                    m_owner = (m_last + k) % 16;
                end
            end
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_held = 1;
            end
        end else if (rel || !req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_held >= HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
`else
            m_held++;
`endif
        end
    endtask

    // Apply inputs, clock once, compare every output with the model.
    task automatic cycle(input logic [15:0] req, input logic rel);
        logic [15:0] eg;
        req_in     = req;
        release_in = rel;
        @(posedge clk_in);
        model_step(req, rel);
        @(negedge clk_in);
        eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        $display("req=%04h rel=%0d -> grant=%04h sel=%0d valid=%0d to=%0d",
                 req, rel, grant_out, sel_out, valid_out, timeout_out);
        chk("model_grant", 32'(grant_out), 32'(eg));
        chk("model_sel", 32'(sel_out), 32'(m_sel));
        chk("model_valid", 32'(valid_out), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout_out), 32'(m_to));
    endtask

    task automatic do_reset();
        rst_n_in   = 1'b0;
        req_in     = 16'd0;
        release_in = 1'b0;
        repeat (2) @(negedge clk_in);
        model_reset();
        chk("reset_grant", 32'(grant_out), 32'h0);
        chk("reset_sel", 32'(sel_out), 32'h0);
        chk("reset_valid", 32'(valid_out), 32'h0);
        chk("reset_timeout", 32'(timeout_out), 32'h0);
        rst_n_in = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        logic        rl;
        n_vec = 0;
        n_err = 0;
        model_reset();

        // Directed table: single request, wrap 14->15->0->1, no preemption, request drop.
        tbl[0]  = '{16'h0020, 1'b0, 16'h0020, 4'd5,  1'b1};
        tbl[1]  = '{16'h0020, 1'b0, 16'h0020, 4'd5,  1'b1};
        tbl[2]  = '{16'h0020, 1'b1, 16'h0000, 4'd5,  1'b0};
        tbl[3]  = '{16'h0000, 1'b0, 16'h0000, 4'd5,  1'b0};
        tbl[4]  = '{16'h4000, 1'b0, 16'h4000, 4'd14, 1'b1};
        tbl[5]  = '{16'h8003, 1'b1, 16'h0000, 4'd14, 1'b0};
        tbl[6]  = '{16'h8003, 1'b0, 16'h8000, 4'd15, 1'b1};
        tbl[7]  = '{16'h8003, 1'b1, 16'h0000, 4'd15, 1'b0};
        tbl[8]  = '{16'h8003, 1'b0, 16'h0001, 4'd0,  1'b1};
        tbl[9]  = '{16'h8007, 1'b0, 16'h0001, 4'd0,  1'b1};
        tbl[10] = '{16'h8007, 1'b1, 16'h0000, 4'd0,  1'b0};
        tbl[11] = '{16'h8003, 1'b0, 16'h0002, 4'd1,  1'b1};
        tbl[12] = '{16'h000A, 1'b1, 16'h0000, 4'd1,  1'b0};
        tbl[13] = '{16'h0008, 1'b0, 16'h0008, 4'd3,  1'b1};
        tbl[14] = '{16'h0010, 1'b0, 16'h0000, 4'd3,  1'b0};
        tbl[15] = '{16'h0011, 1'b0, 16'h0010, 4'd4,  1'b1};
        tbl[16] = '{16'h0000, 1'b1, 16'h0000, 4'd4,  1'b0};

        do_reset();
        for (int i = 0; i <= 16; i++) begin
            cycle(tbl[i].req, tbl[i].rel);
            chk($sformatf("tbl%0d_grant", i), 32'(grant_out), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_sel", i), 32'(sel_out), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].v));
        end

        // Asynchronous reset in the middle of owner 7's grant.
        do_reset();
        cycle(16'h0080, 1'b0);
        chk("pre_reset_sel", 32'(sel_out), 32'd7);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async_reset_grant", 32'(grant_out), 32'h0);
        chk("async_reset_sel", 32'(sel_out), 32'h0);
        chk("async_reset_valid", 32'(valid_out), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();

        // Rotation under all-ones requests, one dead cycle between grants.
        for (int g = 0; g < 17; g++) begin
            cycle(16'hFFFF, 1'b0);
            chk("rot_sel", 32'(sel_out), 32'(g % 16));
            chk("rot_valid", 32'(valid_out), 32'h1);
            cycle(16'hFFFF, 1'b1);
            chk("rot_dead", 32'(valid_out), 32'h0);
        end

`ifdef ARB_TIMEOUT_EN
        // Timeout: one requester held forever, four cycles of ownership then a forced drop.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            cycle(16'h0001, 1'b0);
            chk("to_valid", 32'(valid_out), 32'((c % 5) != 4));
            chk("to_pulse", 32'(timeout_out), 32'((c % 5) == 4));
        end
        // Voluntary release at the limit: no pulse.
        do_reset();
        for (int c = 0; c < 3; c++) cycle(16'h0001, 1'b0);
        cycle(16'h0001, 1'b1);
        chk("to_voluntary", 32'(timeout_out), 32'h0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(3))
                0:       r = 16'd0;
                1:       r = 16'd1 << $urandom_range(15);
                default: r = 16'($urandom());
            endcase
            if (m_owner >= 0 && $urandom_range(7) != 0) r[m_owner] = 1'b1;
            rl = ($urandom_range(3) == 0);
            cycle(r, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter sharing one 16:1 datapath mux (mux16, BUS_WIDTH-wide) among 16 requesters.
- Produces a registered one-hot grant and a 4-bit select that drives the mux select input directly.
- The owner holds the mux until it releases or drops its request.
- Sits between requesting units (register-file read ports, forwarding sources) and the shared mux.

Parameters:
- HOLD_MAX, 64: maximum GRANT cycles before forced release (1..255). Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  asynchronous active-low reset
- req_in  input  16  request vector; bit i = requester i
- release_in  input  1  current owner finished; sampled only in GRANT
- grant_out  output  16  registered one-hot grant; all-zero when no owner
- sel_out  output  4  registered index of owner; connects to the mux select input
- valid_out  output  1  high while grant_out is non-zero (mux output is meaningful)
- timeout_out  output  1  one-cycle pulse on forced release

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n_in is asynchronous and active-low.
- Reset (asserted at any time, including mid-grant) takes effect immediately:
  - state=IDLE
  - grant_out=0, sel_out=0, valid_out=0, timeout_out=0
  - ptr=15 (last-granted index), hold counter=0
- State IDLE:
  - If req_in==0, stay IDLE; outputs hold (sel_out retains its last value, grant_out=0, valid_out=0).
  - Else select the first set bit searching upward from (ptr+1) mod 16, wrapping 15->0.
  - Next edge: grant_out=one-hot(idx), sel_out=idx, valid_out=1, state=GRANT.
  - Latency: request sampled at edge t -> grant visible after edge t+1.
- State GRANT:
  - Owner keeps the grant while req_in[owner]=1 and release_in=0.
  - No preemption: other requests are ignored, whatever their index.
  - If release_in=1 or req_in[owner]=0 (either or both in the same cycle), then at the next edge: grant_out=0, valid_out=0, ptr=owner, state=IDLE.
  - sel_out is not cleared on release.
- Turnaround: one dead cycle between owners.
  - release sampled at edge t -> grant_out=0 after edge t+1 -> new grant after edge t+2.
  - This guarantees the mux select never switches while valid_out=1.
- Fairness:
  - The just-released owner has lowest priority in the next arbitration.
  - Under continuous all-ones requests, each requester is granted once per 16 grants.
- sel_out always equals the index of the single set bit of grant_out whenever valid_out=1.
- No illegal states: any unreachable state encoding returns to IDLE with outputs cleared.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 with no release, the next edge performs the normal release sequence (grant_out=0, ptr=owner, IDLE) and pulses timeout_out=1 for exactly one cycle.
  - Max continuous ownership is HOLD_MAX cycles.
  - A voluntary release in the same cycle as the limit counts as a normal release: no timeout_out pulse.
- Not defined:
  - No counter logic is built; timeout_out is tied 0.
  - Ownership is unbounded.
  - The port list is identical in both builds.

Test Plan:
- Reset: assert rst_n_in=0 mid-grant (owner 7) -> grant_out=0, sel_out=0, valid_out=0 immediately, without waiting for a clock edge.
- Single request: req_in=16'h0020 -> one edge later grant_out=16'h0020, sel_out=5, valid_out=1. Then pulse release_in -> grant_out=0 next edge, sel_out stays 5.
- Rotation: req_in=16'hFFFF held, release_in pulsed one cycle after each grant -> sel_out sequence 0,1,2,...,15,0. Exactly one dead cycle between grants.
- Wrap and no preemption:
  - Owner 14 released with req_in=16'h8003 -> grants 15, then 0, then 1.
  - Raising req_in[2] during owner 0's grant does not disturb owner 0.
- Request drop: owner 3 deasserts req_in[3] with release_in=0 -> treated as release; next grant goes to the next higher requester.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req_in=16'h0001 held, release_in=0 -> valid_out high for exactly 4 cycles, timeout_out pulses once as grant drops, re-grant to 0 two edges after release.
